// File: rtl/c0_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : c0_pkg
//  Description : Shared constants for the C0 datapath: ALU opcodes, flag bit
//                positions, register-write source encodings, reset values.
//  Revision    : 1.0 - initial release
// ============================================================================
package c0_pkg;

    // ALU opcodes (A op B)
    localparam logic [3:0] C_OP_AND  = 4'b0000;
    localparam logic [3:0] C_OP_OR   = 4'b0001;
    localparam logic [3:0] C_OP_XOR  = 4'b0010;
    localparam logic [3:0] C_OP_NOT  = 4'b0011;
    localparam logic [3:0] C_OP_SHL  = 4'b0100;
    localparam logic [3:0] C_OP_SHR  = 4'b0101;
    localparam logic [3:0] C_OP_PASB = 4'b0110;
    localparam logic [3:0] C_OP_PASA = 4'b0111;
    localparam logic [3:0] C_OP_SUB  = 4'b1000;
    localparam logic [3:0] C_OP_ADD  = 4'b1001;
    localparam logic [3:0] C_OP_INC  = 4'b1010;
    localparam logic [3:0] C_OP_DEC  = 4'b1011;
    localparam logic [3:0] C_OP_NEG  = 4'b1100;
    localparam logic [3:0] C_OP_ROL  = 4'b1101;
    localparam logic [3:0] C_OP_ROR  = 4'b1110;
    localparam logic [3:0] C_OP_SWAP = 4'b1111;

    // Flag bit positions inside FLAGS
    localparam int C_FLAG_Z  = 0;
    localparam int C_FLAG_C  = 1;
    localparam int C_FLAG_N  = 2;
    localparam int C_FLAG_V  = 3;
    localparam int C_FLAG_LT = 4;
    localparam int C_FLAG_P  = 5;

    // Register-write source select
    localparam logic [1:0] C_MS_ALU  = 2'b00;
    localparam logic [1:0] C_MS_AREG = 2'b01;
    localparam logic [1:0] C_MS_IMM  = 2'b10;
    localparam logic [1:0] C_MS_MEM  = 2'b11;

    // Upper two flag bits never change; reset image of the whole byte
    localparam logic [1:0] C_FLAGS_FIXED = 2'b01;
    localparam logic [5:0] C_FLAGS_RESET = 6'b000000;

    // 1 when the byte holds an even number of ones
    function automatic logic even_parity(input logic [7:0] v);
        return ~^v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/c0_if.sv
`default_nettype none
// ============================================================================
//  Module      : c0_if
//  Description : Decoded-control bundle from the decoder into the C0 core plus
//                the architectural state the core exposes for observation.
//  Revision    : 1.0 - initial release
// ============================================================================
interface c0_if;
    logic       mem_inst;
    logic       alu_inst;
    logic       jmp_inst;
    logic [1:0] ms;
    logic       irs;
    logic [2:0] rs;
    logic [2:0] ar;
    logic [2:0] bs;
    logic [3:0] op;
    logic [7:0] imm;
    logic [7:0] mem_data;

    logic [7:0] addr;
    logic [7:0] flags;
    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;

    // Decoder side: drives controls, observes state
    modport master (
        output mem_inst, alu_inst, jmp_inst, ms, irs, rs, ar, bs, op, imm, mem_data,
        input  addr, flags, r0, r1, r2, r3, r4, r5, r6, r7
    );

    // Core side: consumes controls, presents state
    modport slave (
        input  mem_inst, alu_inst, jmp_inst, ms, irs, rs, ar, bs, op, imm, mem_data,
        output addr, flags, r0, r1, r2, r3, r4, r5, r6, r7
    );
endinterface
`default_nettype wire

// File: rtl/c0_alu.sv
`default_nettype none
// ============================================================================
//  Module      : c0_alu
//  Description : Purely combinational 8-bit ALU producing a result and the six
//                live flag bits (Z, C, N, V, LT, P).
//  Revision    : 1.0 - initial release
// ============================================================================
module c0_alu
    import c0_pkg::*;
(
    input  wire logic [7:0] i_a,
    input  wire logic [7:0] i_b,
    input  wire logic [3:0] i_op,
    output logic      [7:0] o_result,
    output logic      [5:0] o_flags
);

    logic [7:0] w_res;
    logic [8:0] w_wide;
    logic       w_c;
    logic       w_v;

    // Result, carry/borrow and overflow per opcode; w_wide bit 8 is carry/borrow
    always_comb begin
        w_res  = '0;
        w_wide = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (i_op)
            C_OP_AND:  w_res = i_a & i_b;
            C_OP_OR:   w_res = i_a | i_b;
            C_OP_XOR:  w_res = i_a ^ i_b;
            C_OP_NOT:  w_res = ~i_a;
            C_OP_SHL: begin
                w_res = {i_a[6:0], 1'b0};
                w_c   = i_a[7];
            end
            C_OP_SHR: begin
                w_res = {1'b0, i_a[7:1]};
                w_c   = i_a[0];
            end
            C_OP_PASB: w_res = i_b;
            C_OP_PASA: w_res = i_a;
            C_OP_SUB: begin
                w_wide = {1'b0, i_a} - {1'b0, i_b};
                w_res  = w_wide[7:0];
                w_c    = w_wide[8];
                w_v    = (i_a[7] ^ i_b[7]) & (w_wide[7] ^ i_a[7]);
            end
            C_OP_ADD: begin
                w_wide = {1'b0, i_a} + {1'b0, i_b};
                w_res  = w_wide[7:0];
                w_c    = w_wide[8];
                w_v    = ~(i_a[7] ^ i_b[7]) & (w_wide[7] ^ i_a[7]);
            end
            C_OP_INC: begin
                w_wide = {1'b0, i_a} + 9'd1;
                w_res  = w_wide[7:0];
                w_c    = w_wide[8];
                w_v    = ~i_a[7] & w_wide[7];
            end
            C_OP_DEC: begin
                w_wide = {1'b0, i_a} - 9'd1;
                w_res  = w_wide[7:0];
                w_c    = w_wide[8];
                w_v    = i_a[7] & ~w_wide[7];
            end
            C_OP_NEG: begin
                // Borrow whenever A is nonzero; only 0x80 overflows
                w_wide = 9'd0 - {1'b0, i_a};
                w_res  = w_wide[7:0];
                w_c    = w_wide[8];
                w_v    = i_a[7] & w_wide[7];
            end
            C_OP_ROL: begin
                w_res = {i_a[6:0], i_a[7]};
                w_c   = i_a[7];
            end
            C_OP_ROR: begin
                w_res = {i_a[0], i_a[7:1]};
                w_c   = i_a[0];
            end
            C_OP_SWAP: w_res = {i_a[3:0], i_a[7:4]};
            default:   w_res = '0;
        endcase
    end

    // Assemble the flag vector from the result and the comparison of A and B
    always_comb begin
        o_flags            = '0;
        o_flags[C_FLAG_Z]  = (w_res == 8'd0);
        o_flags[C_FLAG_C]  = w_c;
        o_flags[C_FLAG_N]  = w_res[7];
        o_flags[C_FLAG_V]  = w_v;
        o_flags[C_FLAG_LT] = (i_a < i_b);
        o_flags[C_FLAG_P]  = even_parity(w_res);
    end

    assign o_result = w_res;

endmodule
`default_nettype wire

// File: rtl/c0_core.sv
`default_nettype none
// ============================================================================
//  Module      : c0_core
//  Description : C0 single-cycle datapath: 8x8 register bank, operand muxes,
//                ALU, flags register, conditional branch and instruction
//                pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module c0_core
    import c0_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    c0_if.slave       bus
);

    logic [7:0] r_regs [0:7];
    logic [7:0] r_addr;
    logic [5:0] r_flags;

    logic [7:0] w_areg;
    logic [7:0] w_breg;
    logic [7:0] w_alu_b;
    logic [7:0] w_alu_res;
    logic [5:0] w_alu_flags;
    logic [7:0] w_flags;
    logic [7:0] w_wdata;
    logic       w_wr_en;
    logic       w_taken;

    assign w_areg  = r_regs[bus.ar];
    assign w_breg  = r_regs[bus.bs];
    assign w_alu_b = bus.irs ? bus.imm : w_breg;
    assign w_flags = {C_FLAGS_FIXED, r_flags};
    assign w_wr_en = bus.mem_inst | bus.alu_inst;

    // Condition is tested against the flags held before this edge
    assign w_taken = bus.jmp_inst & (w_flags[bus.op[2:0]] == bus.op[3]);

    c0_alu u_alu (
        .i_a      (w_areg),
        .i_b      (w_alu_b),
        .i_op     (bus.op),
        .o_result (w_alu_res),
        .o_flags  (w_alu_flags)
    );

    // Register-write source selection
    always_comb begin
        w_wdata = w_alu_res;
        case (bus.ms)
            C_MS_ALU:  w_wdata = w_alu_res;
            C_MS_AREG: w_wdata = w_areg;
            C_MS_IMM:  w_wdata = bus.imm;
            C_MS_MEM:  w_wdata = bus.mem_data;
            default:   w_wdata = w_alu_res;
        endcase
    end

    // Register bank: one write port, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[bus.rs] <= w_wdata;
        end
    end

    // Flags load from the ALU on ALU instructions only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= C_FLAGS_RESET;
        end else if (bus.alu_inst) begin
            r_flags <= w_alu_flags;
        end
    end

    // Instruction pointer: branch target or sequential, wrapping at 8 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (w_taken) begin
            r_addr <= bus.imm;
        end else begin
            r_addr <= r_addr + 8'd1;
        end
    end

    assign bus.addr  = r_addr;
    assign bus.flags = w_flags;
    assign bus.r0    = r_regs[0];
    assign bus.r1    = r_regs[1];
    assign bus.r2    = r_regs[2];
    assign bus.r3    = r_regs[3];
    assign bus.r4    = r_regs[4];
    assign bus.r5    = r_regs[5];
    assign bus.r6    = r_regs[6];
    assign bus.r7    = r_regs[7];

endmodule
`default_nettype wire

// File: tb/tb_c0_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_c0_core
//  Description : Scoreboard bench for c0_core with an arithmetic reference
//                model, directed scenarios and randomized instruction streams.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_c0_core;

    logic clk = 1'b0;
    logic rst = 1'b1;

    c0_if bus ();

    c0_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]      addr;
        logic [7:0]      flags;
        logic [7:0][7:0] r;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference architectural state
    int m_r [8];
    int m_addr;
    int m_flags;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dut_reg(input int i);
        case (i)
            0: return int'(bus.r0);
            1: return int'(bus.r1);
            2: return int'(bus.r2);
            3: return int'(bus.r3);
            4: return int'(bus.r4);
            5: return int'(bus.r5);
            6: return int'(bus.r6);
            default: return int'(bus.r7);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_addr  = 0;
        m_flags = 64;
    endtask

    function automatic int ones(input int v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += (v >> i) & 1;
        return n;
    endfunction

    function automatic int to_signed(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Apply one instruction at the current (falling) edge, predict, wait a cycle
    task automatic step(input int mem, input int alu, input int jmp, input int ms,
                        input int irs, input int rs, input int ar, input int bs,
                        input int op, input int imm, input int mdata);
        int a, b, res, c, v, s, t, wval, nflags, taken;
        exp_t e;
        bus.mem_inst = mem[0];
        bus.alu_inst = alu[0];
        bus.jmp_inst = jmp[0];
        bus.ms       = ms[1:0];
        bus.irs      = irs[0];
        bus.rs       = rs[2:0];
        bus.ar       = ar[2:0];
        bus.bs       = bs[2:0];
        bus.op       = op[3:0];
        bus.imm      = imm[7:0];
        bus.mem_data = mdata[7:0];

        a = m_r[ar];
        b = (irs != 0) ? imm : m_r[bs];
        c = 0;
        v = 0;
        res = 0;
        case (op)
            0:  res = a & b;
            1:  res = a | b;
            2:  res = a ^ b;
            3:  res = 255 - a;
            4:  begin res = (a * 2) % 256; c = a / 128; end
            5:  begin res = a / 2; c = a % 2; end
            6:  res = b;
            7:  res = a;
            8:  begin t = a - b; res = (t + 256) % 256; c = (t < 0);
                      s = to_signed(a) - to_signed(b); v = (s > 127 || s < -128); end
            9:  begin t = a + b; res = t % 256; c = (t > 255);
                      s = to_signed(a) + to_signed(b); v = (s > 127 || s < -128); end
            10: begin t = a + 1; res = t % 256; c = (t > 255);
                      s = to_signed(a) + 1; v = (s > 127); end
            11: begin t = a - 1; res = (t + 256) % 256; c = (t < 0);
                      s = to_signed(a) - 1; v = (s < -128); end
            12: begin t = 0 - a; res = (t + 256) % 256; c = (t < 0);
                      s = 0 - to_signed(a); v = (s > 127); end
            13: begin res = (a * 2) % 256 + a / 128; c = a / 128; end
            14: begin res = a / 2 + (a % 2) * 128; c = a % 2; end
            default: res = (a % 16) * 16 + a / 16;
        endcase
        nflags = 64 + (res == 0) + 2 * c + 4 * (res / 128) + 8 * v
               + 16 * (a < b) + 32 * ((ones(res) % 2) == 0);

        case (ms)
            0: wval = res;
            1: wval = a;
            2: wval = imm;
            default: wval = mdata;
        endcase

        taken = (jmp != 0) && (((m_flags >> (op % 8)) & 1) == (op / 8));
        if (mem != 0 || alu != 0) m_r[rs] = wval;
        if (alu != 0) m_flags = nflags;
        m_addr = (taken != 0) ? imm : (m_addr + 1) % 256;

        e.addr  = m_addr[7:0];
        e.flags = m_flags[7:0];
        for (int i = 0; i < 8; i++) e.r[i] = m_r[i][7:0];
        sb_q.push_back(e);

        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"}, int'(bus.addr), 0);
        check({tag, "_flags"}, int'(bus.flags), 8'h40);
        for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", tag, i), dut_reg(i), 0);
    endtask

    // Monitor: after every edge compare the DUT against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_addr", int'(bus.addr), int'(e.addr));
                check("sb_flags", int'(bus.flags), int'(e.flags));
                for (int i = 0; i < 8; i++)
                    check($sformatf("sb_r%0d", i), dut_reg(i), int'(e.r[i]));
            end
        end
    end

    initial begin
        bus.mem_inst = 1'b0;
        bus.alu_inst = 1'b0;
        bus.jmp_inst = 1'b0;
        bus.ms       = 2'b00;
        bus.irs      = 1'b0;
        bus.rs       = 3'd0;
        bus.ar       = 3'd0;
        bus.bs       = 3'd0;
        bus.op       = 4'd0;
        bus.imm      = 8'd0;
        bus.mem_data = 8'd0;
        model_reset();

        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        //   mem alu jmp ms irs rs ar bs op  imm  mdata
        step(0, 0, 1, 0, 0, 0, 0, 0, 7,  0,   0);
        check("jmp_uncond_addr", int'(bus.addr), 0);
        step(1, 0, 0, 2, 0, 0, 0, 0, 0,  10,  0);
        check("seq_addr1", int'(bus.addr), 1);
        step(1, 0, 0, 2, 0, 1, 0, 0, 0,  20,  0);
        check("ld_r0", int'(bus.r0), 10);
        check("ld_r1", int'(bus.r1), 20);
        check("seq_addr2", int'(bus.addr), 2);
        step(0, 1, 0, 0, 0, 0, 0, 1, 8,  0,   0);
        check("sub_r0", int'(bus.r0), 246);
        check("sub_flags", int'(bus.flags), 8'h76);
        step(0, 0, 1, 0, 0, 0, 0, 0, 4,  20,  0);
        check("br_not_taken", int'(bus.addr), 4);
        step(0, 0, 1, 0, 0, 0, 0, 0, 12, 20,  0);
        check("br_taken", int'(bus.addr), 20);
        step(0, 0, 1, 0, 0, 0, 0, 0, 15, 99,  0);
        check("br_never", int'(bus.addr), 21);
        step(1, 0, 0, 2, 0, 0, 0, 0, 0,  127, 0);
        step(0, 1, 0, 0, 1, 0, 0, 0, 9,  1,   0);
        check("add_ovf_r0", int'(bus.r0), 128);
        check("add_ovf_flags", int'(bus.flags), 8'h4C);
        step(1, 0, 0, 2, 0, 2, 0, 0, 0,  255, 0);
        step(0, 1, 0, 0, 1, 2, 2, 0, 10, 0,   0);
        check("inc_wrap_r2", int'(bus.r2), 0);
        check("inc_wrap_flags", int'(bus.flags), 8'h63);
        step(1, 0, 0, 3, 0, 5, 0, 0, 0,  0,   8'hA5);
        check("ld_mem_r5", int'(bus.r5), 8'hA5);
        step(1, 0, 0, 1, 0, 6, 5, 0, 0,  0,   0);
        check("copy_r6", int'(bus.r6), 8'hA5);

        // Jump home, then free-run a full address space with no jumps
        step(0, 0, 1, 0, 0, 0, 0, 0, 7,  0,   0);
        for (int i = 0; i < 256; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("addr_wrap", int'(bus.addr), 0);

        // Randomized instruction stream with occasional combined strobes
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) == 0) ? 1 : 0,
                 ($urandom_range(0, 1) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) == 0) ? 1 : 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        // Mid-cycle reset with a write pending: nothing predicted for this edge
        bus.mem_inst = 1'b1;
        bus.alu_inst = 1'b1;
        bus.jmp_inst = 1'b0;
        bus.ms       = 2'b10;
        bus.rs       = 3'd3;
        bus.imm      = 8'hAA;
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        check_reset_state("midrst_hold");
        model_reset();
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            step(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        @(posedge clk);
        #2;
        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
